// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: bus widths, opcode map and fetch-state encoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 4;
    localparam int unsigned CPU_DATA_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StDeliver,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads the ROM at the PC, advances the PC, latches the
// byte into the instruction register and hands it to the decoder over valid/ready.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter logic [3:0]  HLT_OP = OP_HLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_count,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted,
    output logic [7:0]        fetch_cnt
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [7:0]        fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ir_q        <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        fetch_cnt_d = fetch_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StT1;
            end
            StT1: begin
                state_d = StT2;
            end
            StT2: begin
                ir_d    = mem_data;
                valid_d = 1'b1;
                state_d = StDeliver;
            end
            StDeliver: begin
                if (valid_q && instr_ready) begin
                    valid_d     = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + 8'd1;
                    if (ir_q[DATA_W-1 -: 4] == HLT_OP) begin
                        halted_d = 1'b1;
                        state_d  = StHalted;
                    end else if (run) begin
                        state_d = StT1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes come straight from the state register so reset kills them without a clock.
    assign mem_rd      = (state_q == StT1);
    assign pc_enable   = (state_q == StT2);
    assign mem_addr    = (state_q == StT1) ? pc_count : '0;

    assign ir          = ir_q;
    assign opcode      = ir_q[DATA_W-1 -: 4];
    assign operand     = ir_q[3:0];
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that consumes the program counter's output. It drives the PC's increment enable, addresses the 16x8 instruction ROM, latches the fetched byte into an instruction register, and hands it to the decode/execute stage over a valid/ready handshake.
- Sits between program_counter, the instruction ROM and the decoder in the 8-bit microprocessor.

Parameters:
- ADDR_W, 4, PC/ROM address width; must match the program counter's count width.
- DATA_W, 8, instruction width; upper 4 bits are the opcode, lower 4 bits the operand.
- HLT_OP, 4'hF, opcode that stops fetching.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 = fetch instructions, sampled in IDLE and on handshake completion.
- pc_count  input  ADDR_W  current program counter value.
- pc_enable  output  1  PC increment enable; PC advances on the rising edge where this is 1.
- mem_addr  output  ADDR_W  ROM address.
- mem_rd  output  1  ROM read strobe; ROM registers its output on the edge ending the mem_rd cycle.
- mem_data  input  DATA_W  ROM read data, valid the cycle after mem_rd.
- ir  output  DATA_W  instruction register.
- opcode  output  4  ir[7:4].
- operand  output  4  ir[3:0].
- instr_valid  output  1  ir holds an undelivered instruction.
- instr_ready  input  1  decoder accepts ir.
- halted  output  1  HLT fetched and delivered.
- fetch_cnt  output  8  count of delivered instructions, wraps 255->0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ir=0, instr_valid=0, halted=0, fetch_cnt=0, mem_addr=0. pc_enable and mem_rd go to 0 immediately, including when reset is asserted mid-fetch.
- pc_enable and mem_rd are decoded from the state register only (no input paths); they are never 1 outside T2 and T1 respectively.
- FSM states: IDLE, T1, T2, DELIVER, HALTED.
- IDLE: all strobes 0. Goes to T1 when run=1.
- T1: mem_rd=1, mem_addr=pc_count (combinational). Unconditionally goes to T2.
- T2:
  - pc_enable=1 for exactly this cycle; mem_data is valid.
  - At the edge ending T2: ir<=mem_data, instr_valid<=1, state->DELIVER.
  - The PC increments at that same edge.
- DELIVER: instr_valid=1 and ir stays stable until the edge where instr_valid&&instr_ready.
  - At the handshake edge: instr_valid<=0 and fetch_cnt<=fetch_cnt+1.
  - If opcode==HLT_OP: halted<=1, state->HALTED.
  - Else if run=1: ->T1.
  - Else: ->IDLE.
- HALTED: all strobes 0, halted=1. Left only by reset; run is ignored.
- Latency: from run sampled 1 in IDLE, instr_valid rises after 3 edges. With instr_ready held at 1, throughput is 1 instruction per 3 cycles (T1,T2,DELIVER).
- run deasserted during T1 or T2: the fetch in flight completes and is delivered, then the block goes to IDLE.
- Address wrap: the PC wraps 15->0; the sequencer fetches address 0 next with no special handling.
- Backpressure: pc_enable stays 0 while waiting in DELIVER, so the PC never runs ahead of an undelivered instruction.
- Each instruction address is read exactly once per delivered instruction.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch-state encoding (IDLE, T1, T2, DELIVER, HALTED);
  - opcode constants, including HLT_OP=4'hF;
  - ADDR_W/DATA_W defaults shared with program_counter and the ROM.
- No sub-module. The FSM and IR register live in one module; the bench instantiates the real program_counter plus a behavioural synchronous ROM.

Test Plan:
- Reset then run=1, instr_ready=1, ROM[0..2]=8'h1A,8'h2B,8'h3C -> ir sequence 1A,2B,3C with instr_valid pulses every 3 cycles; pc_enable is a 1-cycle pulse per fetch; pc_count=3 after the third delivery; fetch_cnt=3.
- instr_ready=0 for 10 cycles after the first fetch -> ir=8'h1A stable, instr_valid=1, pc_enable=0 throughout, pc_count stays 1; release -> handshake, fetch_cnt=1.
- ROM[3]=8'hF0 -> after delivering F0, halted=1, pc_count=4, no further mem_rd for 20 cycles even with run=1.
- Fill ROM with non-HLT values, run 16+ fetches -> mem_addr goes 15 then 0; the ir at address 0 matches ROM[0].
- Assert rst_n=0 asynchronously in T2 (mid-cycle) -> pc_enable, instr_valid, ir go 0 before the next edge; the PC does not increment.
- Drop run during T1 -> the current instruction is still delivered, then IDLE with mem_rd=0; reassert run -> fetch resumes at the next pc_count.
